// File: rtl/gpu_cmd_sequencer.sv
// Command sequencer: replays queued GPU register writes on the slave bus, waits for irq after
// operation starts, acknowledges via status read, and runs the error-clear handshake on faults.
module gpu_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_addr,
  input  logic [31:0]                  cmd_data,
  output logic [7:0]                   g_address,
  output logic                         g_write,
  output logic [31:0]                  g_writedata,
  output logic                         g_read,
  input  logic [31:0]                  g_readdata,
  input  logic                         g_waitrequest,
  input  logic                         g_irq,
  output logic                         busy,
  output logic                         err,
  output logic [1:0]                   err_code,
  input  logic                         err_clear,
  output logic [15:0]                  done_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  STATUS_ADDR = 8'h0f;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ISSUE       = 3'd1;
  localparam logic [2:0] S_WAIT_IRQ    = 3'd2;
  localparam logic [2:0] S_READ_STATUS = 3'd3;
  localparam logic [2:0] S_CLEAR_ERR   = 3'd4;
  localparam logic [2:0] S_HALT        = 3'd5;

  logic [39:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   level_q, level_d;
  logic [2:0]    state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [1:0]    clr_q, clr_d;
  logic [1:0]    code_q, code_d;
  logic [15:0]   done_q, done_d;
  logic          wr_d, rd_d;
  logic [7:0]    addr_d;
  logic [31:0]   wdata_d;
  logic          push, pop, fifo_empty, head_legal;
  logic [7:0]    head_addr;
  logic [31:0]   head_data;

  assign fifo_empty = (level_q == '0);
  assign cmd_ready  = (level_q != FULL_LEVEL);
  assign push       = cmd_valid && cmd_ready;
  assign head_addr  = mem[rd_ptr_q][39:32];
  assign head_data  = mem[rd_ptr_q][31:0];
  assign head_legal = (head_addr <= 8'h03) || ((head_addr >= 8'h10) && (head_addr <= 8'h1e));

  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign err        = (state_q == S_HALT);
  assign err_code   = code_q;
  assign done_count = done_q;
  assign fifo_level = level_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    clr_d   = clr_q;
    code_d  = code_q;
    done_d  = done_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head_legal) begin
            state_d = S_ISSUE;
          end else begin
            pop     = 1'b1;
            code_d  = 2'd3;
            state_d = S_HALT;
          end
        end
      end
      S_ISSUE: begin
        if (!g_waitrequest) begin
          pop = 1'b1;
          if (head_addr <= 8'h03) begin
            state_d = S_WAIT_IRQ;
            timer_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IRQ: begin
        // irq in the final cycle takes priority over the timeout
        if (g_irq) begin
          state_d = S_READ_STATUS;
        end else if (timer_q == TIMER_LAST) begin
          code_d  = 2'd2;
          clr_d   = 2'd2;
          state_d = S_CLEAR_ERR;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_READ_STATUS: begin
        if (!g_waitrequest) begin
          if (g_readdata == '0) begin
            done_d  = done_q + 16'd1;
            state_d = S_IDLE;
          end else begin
            code_d  = 2'd1;
            clr_d   = 2'd1;
            state_d = S_CLEAR_ERR;
          end
        end
      end
      S_CLEAR_ERR: begin
        if (!g_waitrequest) begin
          clr_d = clr_q - 2'd1;
          if (clr_q == 2'd1) state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (err_clear) begin
          state_d = S_IDLE;
          code_d  = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      S_ISSUE: begin
        wr_d    = 1'b1;
        addr_d  = head_addr;
        wdata_d = head_data;
      end
      S_READ_STATUS: begin
        rd_d   = 1'b1;
        addr_d = STATUS_ADDR;
      end
      S_CLEAR_ERR: begin
        wr_d    = 1'b1;
        addr_d  = STATUS_ADDR;
        wdata_d = 32'd1;
      end
      default: ;
    endcase
  end

  assign level_d = level_q + (PW + 1)'(push) - (PW + 1)'(pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {cmd_addr, cmd_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      clr_q       <= '0;
      code_q      <= '0;
      done_q      <= '0;
      level_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      g_write     <= 1'b0;
      g_read      <= 1'b0;
      g_address   <= '0;
      g_writedata <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      clr_q       <= clr_d;
      code_q      <= code_d;
      done_q      <= done_d;
      level_q     <= level_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      g_write     <= wr_d;
      g_read      <= rd_d;
      g_address   <= addr_d;
      g_writedata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Bench for gpu_cmd_sequencer: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the sequencer's documented behaviour.
module tb_gpu_cmd_sequencer;

  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic        clock, reset;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [7:0]  g_address;
  logic        g_write, g_read;
  logic [31:0] g_writedata, g_readdata;
  logic        g_waitrequest, g_irq;
  logic        busy, err, err_clear;
  logic [1:0]  err_code;
  logic [15:0] done_count;
  logic [4:0]  fifo_level;

  gpu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .g_address(g_address), .g_write(g_write), .g_writedata(g_writedata), .g_read(g_read),
    .g_readdata(g_readdata), .g_waitrequest(g_waitrequest), .g_irq(g_irq),
    .busy(busy), .err(err), .err_code(err_code), .err_clear(err_clear),
    .done_count(done_count), .fifo_level(fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [7:0] a);
    return (a <= 8'h03) || (a >= 8'h10 && a <= 8'h1e);
  endfunction

  // Reference model: spec-level phases, FIFO as a queue.
  typedef enum int {MIdle, MIssue, MWait, MRead, MClear, MHalt} mphase_t;
  mphase_t     m_ph;
  logic [39:0] m_q[$];
  logic [39:0] m_head;
  int          m_waited, m_clr, m_code, m_done;
  bit          m_valid = 0;
  bit          m_push;
  logic        e_wr, e_rd;
  logic [7:0]  e_addr;
  logic [31:0] e_data;

  always @(negedge clock) begin
    m_head = (m_q.size() > 0) ? m_q[0] : 40'd0;
    if (m_valid) begin
      e_wr = 0; e_rd = 0; e_addr = 0; e_data = 0;
      if (m_ph == MIssue) begin e_wr = 1; e_addr = m_head[39:32]; e_data = m_head[31:0]; end
      if (m_ph == MRead)  begin e_rd = 1; e_addr = 8'h0f; end
      if (m_ph == MClear) begin e_wr = 1; e_addr = 8'h0f; e_data = 32'd1; end
      chk("g_write", g_write, e_wr);
      chk("g_read", g_read, e_rd);
      chk("g_address", g_address, e_addr);
      chk("g_writedata", g_writedata, e_data);
      chk("busy", busy, (m_ph != MIdle || m_q.size() != 0));
      chk("err", err, (m_ph == MHalt));
      chk("err_code", err_code, m_code);
      chk("done_count", done_count, m_done);
      chk("fifo_level", fifo_level, m_q.size());
      chk("cmd_ready", cmd_ready, (m_q.size() != DEPTH));
    end
    if (reset) begin
      m_ph = MIdle; m_q.delete(); m_waited = 0; m_clr = 0; m_code = 0; m_done = 0; m_valid = 1;
    end else if (m_valid) begin
      m_push = cmd_valid && (m_q.size() < DEPTH);
      case (m_ph)
        MIdle: if (m_q.size() > 0) begin
          if (legal(m_head[39:32])) m_ph = MIssue;
          else begin void'(m_q.pop_front()); m_code = 3; m_ph = MHalt; end
        end
        MIssue: if (!g_waitrequest) begin
          void'(m_q.pop_front());
          if (m_head[39:32] <= 8'h03) begin m_ph = MWait; m_waited = 0; end
          else m_ph = MIdle;
        end
        MWait: if (g_irq) m_ph = MRead;
        else begin
          m_waited++;
          if (m_waited == TO) begin m_code = 2; m_clr = 2; m_ph = MClear; end
        end
        MRead: if (!g_waitrequest) begin
          if (g_readdata == 0) begin m_done = (m_done + 1) % 65536; m_ph = MIdle; end
          else begin m_code = 1; m_clr = 1; m_ph = MClear; end
        end
        MClear: if (!g_waitrequest) begin
          m_clr--;
          if (m_clr == 0) m_ph = MHalt;
        end
        MHalt: if (err_clear) begin m_ph = MIdle; m_code = 0; end
        default: ;
      endcase
      if (m_push) m_q.push_back({cmd_addr, cmd_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1; cmd_addr = a; cmd_data = d;
  endtask

  logic [7:0] ra;

  initial begin
    reset = 1; cmd_valid = 0; cmd_addr = 0; cmd_data = 0; g_readdata = 0;
    g_waitrequest = 0; g_irq = 0; err_clear = 0;
    tick(3);
    reset = 0;
    tick(1);
    chk("rst fifo_level", fifo_level, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst g_write", g_write, 0);
    chk("rst g_address", g_address, 0);

    // Camera write
    push(8'h10, 32'h12345678);
    tick(1); cmd_valid = 0;
    chk("cam level", fifo_level, 1);
    tick(1);
    chk("cam g_write", g_write, 1);
    chk("cam addr", g_address, 8'h10);
    chk("cam data", g_writedata, 32'h12345678);
    tick(1);
    chk("cam busy", busy, 0);
    chk("cam done", done_count, 0);

    // Op with irq, then a queued camera write
    push(8'h00, 32'hA5);
    tick(1); push(8'h11, 32'hCAFEF00D);
    tick(1); cmd_valid = 0;
    chk("op addr", g_address, 8'h00);
    tick(6); g_irq = 1;
    tick(1); g_irq = 0;
    chk("op g_read", g_read, 1);
    chk("op rd addr", g_address, 8'h0f);
    tick(1);
    chk("op done", done_count, 1);
    tick(1);
    chk("op next cam", g_address, 8'h11);
    tick(1);

    // GPU error with queued commands held until err_clear
    push(8'h01, 32'd5);
    tick(1); push(8'h12, 32'h77);
    tick(1); push(8'h13, 32'h88);
    tick(1); cmd_valid = 0; g_irq = 1;
    tick(1); g_irq = 0; g_readdata = 32'd2;
    tick(1); g_readdata = 0;
    chk("gerr clr addr", g_address, 8'h0f);
    chk("gerr clr data", g_writedata, 1);
    chk("gerr code", err_code, 1);
    tick(1);
    chk("gerr err", err, 1);
    tick(3);
    chk("gerr held level", fifo_level, 2);
    chk("gerr held wr", g_write, 0);
    err_clear = 1;
    tick(1); err_clear = 0;
    chk("gerr cleared", err_code, 0);
    tick(1);
    chk("gerr resume a", g_address, 8'h12);
    tick(2);
    chk("gerr resume b", g_writedata, 32'h88);
    tick(1);

    // Timeout
    push(8'h02, 32'd9);
    tick(1); cmd_valid = 0;
    tick(1);
    chk("to op", g_address, 8'h02);
    tick(8);
    chk("to still waiting", g_write, 0);
    tick(1);
    chk("to clr1", g_address, 8'h0f);
    chk("to code", err_code, 2);
    tick(1);
    chk("to clr2", g_write, 1);
    tick(1);
    chk("to halt", err, 1);
    err_clear = 1;
    tick(1); err_clear = 0;

    // Illegal address
    push(8'h07, 32'h55);
    tick(1); cmd_valid = 0;
    chk("ill level", fifo_level, 1);
    tick(1);
    chk("ill code", err_code, 3);
    chk("ill level after", fifo_level, 0);
    chk("ill no bus", g_write, 0);
    err_clear = 1;
    tick(1); err_clear = 0;

    // Backpressure
    push(8'h14, 32'hDEADBEEF);
    tick(1); cmd_valid = 0; g_waitrequest = 1;
    tick(1);
    chk("bp data", g_writedata, 32'hDEADBEEF);
    tick(3);
    chk("bp held addr", g_address, 8'h14);
    chk("bp level", fifo_level, 1);
    tick(1); g_waitrequest = 0;
    tick(1);
    chk("bp popped", fifo_level, 0);

    // Full FIFO; push coinciding with pop is rejected
    g_waitrequest = 1;
    for (int k = 0; k < 16; k++) begin
      push(8'(8'h10 + k % 15), 32'(k));
      tick(1);
    end
    chk("full level", fifo_level, 16);
    chk("full ready", cmd_ready, 0);
    push(8'h1e, 32'hFFFF);
    g_waitrequest = 0;
    tick(1); cmd_valid = 0;
    chk("full pop no push", fifo_level, 15);
    tick(40);
    chk("full drained", busy, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = (i == 1500);
      cmd_valid = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: ra = 8'($urandom_range(0, 3));
        9: begin
          ra = 8'($urandom_range(0, 255));
          if (legal(ra)) ra = 8'h0f;
        end
        default: ra = 8'(8'h10 + $urandom_range(0, 14));
      endcase
      cmd_addr = ra;
      cmd_data = $urandom;
      g_waitrequest = ($urandom_range(0, 3) == 0);
      g_irq = ($urandom_range(0, 4) == 0);
      g_readdata = ($urandom_range(0, 4) == 0) ? $urandom : 32'd0;
      err_clear = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    reset = 0; cmd_valid = 0; g_waitrequest = 0; g_irq = 1; g_readdata = 0; err_clear = 1;
    for (int i = 0; i < 200 && busy; i++) tick(1);
    chk("final idle", busy, 0);
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_sequencer.md
# gpu_cmd_sequencer

Command sequencer in front of the voxel GPU's register slave. A host pushes (address, data) register writes into an internal FIFO. The sequencer replays them on the GPU slave port one at a time. After every operation-start write (0x00–0x03) it blocks until the GPU raises `irq`, then acknowledges by reading status 0x0f. GPU errors and timeouts halt the queue and run the GPU's error-clear handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: command FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 65535: maximum cycles in WAIT_IRQ before a timeout; range 1..65535.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: host push request.
- `cmd_ready` out 1: FIFO not full.
- `cmd_addr` in 8: GPU register address.
- `cmd_data` in 32: GPU register write data.
- `g_address` out 8: GPU slave address.
- `g_write` out 1: GPU slave write strobe.
- `g_writedata` out 32: GPU slave write data.
- `g_read` out 1: GPU slave read strobe.
- `g_readdata` in 32: GPU slave read data; valid in the same cycle as `g_read` with `!g_waitrequest`.
- `g_waitrequest` in 1: GPU slave stall.
- `g_irq` in 1: GPU interrupt, level.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `err` out 1: sequencer is in HALT.
- `err_code` out 2: 0 none, 1 GPU error, 2 timeout, 3 illegal address.
- `err_clear` in 1: leave HALT.
- `done_count` out 16: completed operations.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Push: accepted when `cmd_valid && cmd_ready`. `cmd_ready = (fifo_level != FIFO_DEPTH)`, taken from registered level. A pop in the same cycle does not free a slot for that cycle's push.
- Legal addresses: 0x00–0x03 (ops) and 0x10–0x1e (camera).
  - An illegal head entry is popped with no bus transaction, and the sequencer goes to HALT with `err_code=3`.
- States:
  - **IDLE**: if the FIFO is non-empty and the head is legal, go to ISSUE; if the head is illegal, apply the rule above.
  - **ISSUE**:
    - Drive `g_write=1`, `g_address=head.addr`, `g_writedata=head.data`. Hold them while `g_waitrequest`.
    - On accept, pop the FIFO. Op address → WAIT_IRQ with the timer cleared; camera address → IDLE.
  - **WAIT_IRQ**:
    - If `g_irq`, go to READ_STATUS.
    - Otherwise increment the timer. When timer == TIMEOUT_CYCLES−1 and `g_irq` is low, set `err_code=2`, arm 2 clear writes, and go to CLEAR_ERR.
  - **READ_STATUS**:
    - Drive `g_read=1`, `g_address=0x0f`. Hold while `g_waitrequest`.
    - On accept, sample `g_readdata`. Value 0 → `done_count++` (wraps at 0xFFFF), go to IDLE.
    - Any nonzero value → `err_code=1`, arm 1 clear write, go to CLEAR_ERR.
  - **CLEAR_ERR**:
    - Drive `g_write=1`, `g_address=0x0f`, `g_writedata=1` for each armed write. Each write holds while `g_waitrequest`.
    - Timeout recovery uses 2 writes: the first forces the GPU into ERROR, the second returns it to IDLE.
    - After the last accepted write, go to HALT.
  - **HALT**:
    - `err=1`; no dispatch; the FIFO still accepts pushes.
    - `err_clear` → IDLE and `err_code=0`. `err_clear` in any other state is ignored.
- `g_read` and `g_write` are never asserted together. Bus outputs are registered.
- When the bus is idle, `g_address`, `g_writedata`, `g_write` and `g_read` are all 0.

## Timing
- Reset values:
  - state IDLE; FIFO empty; `fifo_level=0`; `cmd_ready=1`.
  - `g_write=0`, `g_read=0`, `g_address=0`, `g_writedata=0`.
  - `busy=0`, `err=0`, `err_code=0`, `done_count=0`; timer 0.
- Reset takes effect at the next clock edge, even mid-transaction. Any strobe is dropped in the following cycle.
- Latency: a push accepted at edge N into an empty FIFO in IDLE gives `g_write=1` in cycle N+2.
- Zero-wait camera writes issue back-to-back every 2 cycles (ISSUE, IDLE, ISSUE, …).
- `g_irq` is sampled in WAIT_IRQ. `g_read` asserts in the cycle after `g_irq` is seen high.
- Timeout: the transition happens on the edge ending the TIMEOUT_CYCLES-th WAIT_IRQ cycle with `g_irq` low. `g_irq` high in that cycle wins over the timeout.
- `done_count` and `err_code` update on the edge that leaves READ_STATUS.

## Test plan
- **Camera write**: reset, push {0x10, 0x12345678} → one `g_write` with `g_address=0x10` and `g_writedata=0x12345678` 2 cycles later; `busy` then returns to 0; `done_count` stays 0.
- **Op with irq**: push {0x00, 0xA5}; raise `g_irq` 5 cycles after the write; `g_readdata=0` → one `g_read` at 0x0f, `done_count=1`, state back to IDLE; a queued camera write issues next.
- **GPU error**: op completes with status read 2 → single write {0x0f, 1}, then `err=1`, `err_code=1`. Queued commands are held until `err_clear`, then resume in order.
- **Timeout**: TIMEOUT_CYCLES=8, op issued, `g_irq` never asserted → exactly 8 WAIT_IRQ cycles, two writes {0x0f, 1}, `err_code=2`, no `g_read`.
- **Illegal address**: push {0x07, x} → no bus activity, `err_code=3`, FIFO level decreases by 1.
- **Backpressure and full FIFO**:
  - Hold `g_waitrequest` high for 4 cycles during ISSUE → address and data stay stable, with a single pop.
  - Fill 16 entries → `cmd_ready=0`; a push that coincides with a pop is rejected.
